tank_level_controller: RTL and testbench

//   Producer side of the full_tank interface consumed by irrigation_fsm. It fills the

---
 rtl/tank_level_controller_pkg.sv | 14 +
 rtl/tank_level_controller_level_debouncer.sv | 49 ++++
 rtl/tank_level_controller.sv | 121 ++++++++++++
 tb/tb_tank_level_controller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tank_level_controller_pkg.sv
// Shared definitions for the tank level controller.
//   tank_state_t : FSM state encoding, also driven onto state_dbg so that
//                  checkers and the consumer side can decode it directly.
package tank_level_controller_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILLING   = 3'd1,
        FULL      = 3'd2,
        SUPPLYING = 3'd3,
        FAULT     = 3'd4
    } tank_state_t;

endpackage

// File: rtl/tank_level_controller_level_debouncer.sv
// level_debouncer: synchronises one raw float-switch input and filters bounce.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low
//   raw      : asynchronous, possibly bouncing switch input
//   filtered : debounced level; follows the synchronised input only after it
//              has differed from the current filtered value for
//              DEBOUNCE_CYCLES consecutive cycles
// A clean raw edge reaches filtered 2 + DEBOUNCE_CYCLES rising edges later.
module level_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            filtered   <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            // stable_cnt counts mismatch cycles already seen; the mismatch
            // cycle that finds it at CNT_LAST is the DEBOUNCE_CYCLES-th one.
            if (sync_2 != filtered) begin
                if (stable_cnt == CNT_LAST) begin
                    filtered   <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tank_level_controller.sv
// tank_level_controller: fills the reservoir and tells irrigation_fsm when the
// tank is usable.
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-low
//   level_low   : raw float switch, 1 = water above low mark
//   level_high  : raw float switch, 1 = water above high mark
//   splinker    : sprinkler valve open (from irrigation_fsm)
//   dripper     : dripper valve open (from irrigation_fsm)
//   full_tank   : tank usable (FULL or SUPPLYING)
//   inlet_valve : fill valve open (FILLING)
//   fault       : sticky fault (FAULT, cleared only by reset)
//   state_dbg   : current state encoding
// All outputs decode from the state register alone, so asserting reset
// closes the inlet immediately without waiting for a clock edge.
module tank_level_controller
    import tank_level_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FILL_TIMEOUT    = 1000,
    parameter int CNT_W           = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       level_low,
    input  logic       level_high,
    input  logic       splinker,
    input  logic       dripper,
    output logic       full_tank,
    output logic       inlet_valve,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_TIMEOUT - 1);

    tank_state_t      state_q;
    tank_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             low_f;
    logic             high_f;
    logic             supply_on;

    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_low_deb (
        .clock    (clock),
        .reset    (reset),
        .raw      (level_low),
        .filtered (low_f)
    );

    level_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_high_deb (
        .clock    (clock),
        .reset    (reset),
        .raw      (level_high),
        .filtered (high_f)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        supply_on = splinker | dripper;
        // Water above the high mark but not the low mark cannot happen with
        // working switches; it overrides every other decision.
        if (high_f && !low_f) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE:      state_d = high_f ? FULL : FILLING;
                FILLING: begin
                    // Reaching the high mark wins over a timeout in the same cycle.
                    if (high_f)                 state_d = FULL;
                    else if (cnt_q == CNT_LAST) state_d = FAULT;
                end
                FULL: begin
                    if (!low_f)         state_d = FILLING;
                    else if (supply_on) state_d = SUPPLYING;
                end
                SUPPLYING: begin
                    // Refill only at the low mark, even with valves still open.
                    if (!low_f)          state_d = FILLING;
                    else if (!supply_on) state_d = FULL;
                end
                FAULT:     state_d = FAULT;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Counter runs only while staying in FILLING, so every entry starts at 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == FILLING && state_d == FILLING) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        full_tank   = 1'b0;
        inlet_valve = 1'b0;
        fault       = 1'b0;
        case (state_q)
            FILLING:   inlet_valve = 1'b1;
            FULL:      full_tank   = 1'b1;
            SUPPLYING: full_tank   = 1'b1;
            FAULT:     fault       = 1'b1;
            default:   ;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_tank_level_controller.sv
module tb_tank_level_controller;
    import tank_level_controller_pkg::*;

    logic       clock;
    logic       reset;
    logic       level_low;
    logic       level_high;
    logic       splinker;
    logic       dripper;
    logic       full_tank;
    logic       inlet_valve;
    logic       fault;
    logic [2:0] state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    tank_level_controller #(
        .DEBOUNCE_CYCLES (4),
        .FILL_TIMEOUT    (16),
        .CNT_W           (10)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .level_low   (level_low),
        .level_high  (level_high),
        .splinker    (splinker),
        .dripper     (dripper),
        .full_tank   (full_tank),
        .inlet_valve (inlet_valve),
        .fault       (fault),
        .state_dbg   (state_dbg)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input tank_state_t st,
                             input logic exp_full, input logic exp_inlet, input logic exp_fault);
        check({tag, ".state"}, 32'(state_dbg), 32'(st));
        check({tag, ".full"},  32'(full_tank), 32'(exp_full));
        check({tag, ".inlet"}, 32'(inlet_valve), 32'(exp_inlet));
        check({tag, ".fault"}, 32'(fault), 32'(exp_fault));
    endtask

    // Hold reset over two edges with both sensors low, then release.
    task automatic reset_and_release(input string tag);
        reset      = 1'b0;
        level_low  = 1'b0;
        level_high = 1'b0;
        splinker   = 1'b0;
        dripper    = 1'b0;
        tick(2);
        check_out({tag, "_in_reset"}, IDLE, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        level_low  = 1'b0;
        level_high = 1'b0;
        splinker   = 1'b0;
        dripper    = 1'b0;

        // 1: power-up fill, then low and high marks reached.
        reset_and_release("t1");
        check_out("t1_idle", IDLE, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("t1_filling", FILLING, 1'b0, 1'b1, 1'b0);
        level_low = 1'b1;
        tick(1);
        level_high = 1'b1;
        tick(6);
        check_out("t1_high_plus6", FILLING, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_out("t1_high_plus7", FULL, 1'b1, 1'b0, 1'b0);

        // 3: supply phases, then drain to the low mark with a valve open.
        splinker = 1'b1;
        tick(1);
        check_out("t3_supply", SUPPLYING, 1'b1, 1'b0, 1'b0);
        splinker = 1'b0;
        tick(1);
        check_out("t3_valves_closed", FULL, 1'b1, 1'b0, 1'b0);
        dripper = 1'b1;
        tick(1);
        check_out("t3_drip", SUPPLYING, 1'b1, 1'b0, 1'b0);
        level_high = 1'b0;
        tick(1);
        level_low = 1'b0;
        tick(6);
        check_out("t3_low_plus6", SUPPLYING, 1'b1, 1'b0, 1'b0);
        tick(1);
        check_out("t3_low_plus7", FILLING, 1'b0, 1'b1, 1'b0);
        dripper = 1'b0;

        // 2: bouncing high switch is rejected, then fill timeout.
        //    FILLING was entered on the previous edge, so 14 more edges leave
        //    the counter at 14, still below the limit of 15.
        for (int i = 0; i < 7; i++) begin
            level_high = ~level_high;
            tick(2);
            check("t2_bounce_state", 32'(state_dbg), 32'(FILLING));
        end
        level_high = 1'b0;
        tick(1);
        check_out("t2_cnt15", FILLING, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_out("t2_timeout", FAULT, 1'b0, 1'b0, 1'b1);
        level_low  = 1'b1;
        level_high = 1'b1;
        tick(10);
        check_out("t2_sticky", FAULT, 1'b0, 1'b0, 1'b1);

        // 4: impossible level (high without low) forces FAULT.
        reset_and_release("t4");
        check_out("t4_idle", IDLE, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("t4_filling", FILLING, 1'b0, 1'b1, 1'b0);
        level_high = 1'b1;
        tick(6);
        check_out("t4_plus6", FILLING, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_out("t4_plus7", FAULT, 1'b0, 1'b0, 1'b1);

        // 5: high_f rises in the very cycle the counter sits at 15.
        reset_and_release("t5");
        level_low = 1'b1;
        check_out("t5_idle", IDLE, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("t5_filling", FILLING, 1'b0, 1'b1, 1'b0);
        tick(9);
        level_high = 1'b1;
        tick(6);
        check_out("t5_cnt15", FILLING, 1'b0, 1'b1, 1'b0);
        tick(1);
        check_out("t5_full", FULL, 1'b1, 1'b0, 1'b0);

        // 6: reset between edges mid-fill closes the inlet at once.
        reset_and_release("t6");
        tick(1);
        check_out("t6_filling", FILLING, 1'b0, 1'b1, 1'b0);
        tick(3);
        #3;
        reset = 1'b0;
        #1;
        check_out("t6_async_reset", IDLE, 1'b0, 1'b0, 1'b0);
        tick(1);
        reset = 1'b1;
        check_out("t6_released", IDLE, 1'b0, 1'b0, 1'b0);
        tick(1);
        check_out("t6_refill", FILLING, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
